// File: rtl/mux_rr_nto1.sv
// N-to-1 multiplexor, fixed-select or round-robin, registered output with valid/ready.
// Latency: 1 cycle from accept (in_valid & in_ready) to out_valid; 1 word/cycle sustained.
// Backpressure: output register holds while out_valid & !out_ready; all in_ready low then.
module mux_rr_nto1 #(
  parameter int DW  = 2,
  parameter int NCH = 4,
  localparam int SW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*DW-1:0] in_data,
  output logic [NCH-1:0]    in_ready,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic [SW-1:0]     out_ch,
  input  logic              out_ready
);

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;

  logic          load_en;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [DW-1:0] grant_dat;

  // The register may take a new word when it is empty or its word leaves this cycle.
  assign load_en = !out_valid_q || out_ready;

  // Pick at most one channel: sel in fixed mode (out-of-range sel grants nothing),
  // otherwise the first valid channel searching upward from rr_ptr with wrap.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (!mode) begin
      for (int c = 0; c < NCH; c++) begin
        if (int'(sel) == c && in_valid[c]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(c);
        end
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NCH) begin
          idx = idx - NCH;
        end
        for (int c = 0; c < NCH; c++) begin
          if (!grant_vld && c == idx && in_valid[c]) begin
            grant_vld = 1'b1;
            grant_idx = SW'(c);
          end
        end
      end
    end
  end

  // Route the granted channel's word and raise only its ready; no skid buffer, so
  // ready follows out_ready combinationally through load_en.
  always_comb begin
    grant_dat = '0;
    in_ready  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (grant_idx == SW'(c)) begin
        grant_dat = in_data[c*DW +: DW];
      end
      in_ready[c] = load_en && grant_vld && (grant_idx == SW'(c));
    end
  end

  // Next state: load on a transfer, empty when loading with nothing granted, else hold.
  // The round-robin pointer moves past the winner only on a round-robin transfer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d = grant_dat;
        out_ch_d   = grant_idx;
        if (mode) begin
          if (int'(grant_idx) == NCH - 1) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_idx + SW'(1);
          end
        end
      end
    end
  end

  // State registers; reset discards any held word and restarts arbitration at channel 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
